multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Moore-style FSM that sequences a multicycle MIPS datapath sharing one memory, one ALU and one register file.
//  Decodes opcode_i once per instruction, then steps fetch/decode/execute/memory/writeback while driving all datapath enables and mux selects.
//  Supports R-type (add, sub, and, or, nor), addi, ori, beq, bne, lw and sw.
//  Memory access uses a ready handshake with a timeout watchdog.
// PARAMETERS
//  WAIT_LIMIT  15  max consecutive stalled cycles waiting for mem_ready_i before entering ERROR (1..255)
// PORTS
//  clk           in   1  rising-edge clock
//  reset         in   1  asynchronous, active-high reset
//  opcode_i      in   6  instruction[31:26] from instruction register
//  zero_i        in   1  ALU zero flag
//  mem_ready_i   in   1  memory completes the current access this cycle
//  pc_write_o    out  1  load PC
//  iord_o        out  1  memory address select: 0=PC, 1=ALU out
//  mem_read_o    out  1  memory read request
//  mem_write_o   out  1  memory write request
//  ir_write_o    out  1  load instruction register
//  reg_dst_o     out  1  write-register select: 0=rt, 1=rd
//  mem_to_reg_o  out  1  write-data select: 0=ALU out, 1=memory data reg
//  reg_write_o   out  1  register file write enable
//  alu_src_a_o   out  1  ALU A: 0=PC, 1=reg A
//  alu_src_b_o   out  2  ALU B: 00=reg B, 01=32'h4, 10=ext imm, 11=ext imm<<2
//  alu_op_o      out  3  000=add, 001=sub, 010=use funct, 011=or
//  pc_src_o      out  1  PC source: 0=ALU result, 1=ALU out reg (branch target)
//  state_o       out  4  current state encoding, for debug
//  error_o       out  1  high while in ERROR
// BEHAVIOUR
//  States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, I_EXEC=8,
//   I_WB=9, BRANCH=10, ERROR=15. Encodings 11..14 are unused; if reached, go to ERROR next cycle.
//  Reset: state=FETCH, wait counter=0. While reset is high, all outputs are 0 except state_o=0.
//  FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=000, pc_src=0.
//   ir_write and pc_write are 1 only in the cycle mem_ready_i=1; the FSM then goes to DECODE.
//   Otherwise it holds in FETCH.
//  DECODE: alu_src_a=0, alu_src_b=11, alu_op=000 (branch target precompute). Next state by opcode:
//   000000 -> R_EXEC; 001000 (addi) or 001101 (ori) -> I_EXEC; 100011 (lw) or 101011 (sw) -> MEM_ADDR;
//   000100 (beq) or 000101 (bne) -> BRANCH; any other opcode -> ERROR.
//   The opcode is registered in DECODE for use in later states.
//  MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000 -> MEM_READ (lw) or MEM_WRITE (sw).
//  MEM_READ: iord=1, mem_read=1; holds until mem_ready_i, then -> MEM_WB.
//  MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1 -> FETCH.
//  MEM_WRITE: iord=1, mem_write=1; holds until mem_ready_i, then -> FETCH.
//  R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=010 -> R_WB.
//  R_WB: reg_dst=1, mem_to_reg=0, reg_write=1 -> FETCH.
//  I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=000 (addi) or 011 (ori) -> I_WB.
//  I_WB: reg_dst=0, mem_to_reg=0, reg_write=1 -> FETCH.
//  BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_src=1.
//   pc_write = (beq & zero_i) | (bne & ~zero_i), combinational in this cycle. Always -> FETCH.
//  Any output not listed for a state is 0.
//  Cycles per instruction, with zero wait states: R/I/sw=4, lw=5, beq/bne=3.
//  Wait counter (8 bit):
//   - clears on every state change;
//   - increments each cycle spent in FETCH, MEM_READ or MEM_WRITE with mem_ready_i=0;
//   - when it reaches WAIT_LIMIT with mem_ready_i still 0, the next state is ERROR.
//   mem_ready_i=1 in the same cycle as the limit wins: the access completes normally.
//  ERROR: all strobes 0, error_o=1; sticky until reset.
//  Reset asserted mid-access drops mem_read/mem_write immediately (async); the FSM restarts in FETCH.
//  mem_ready_i is ignored in all states other than FETCH, MEM_READ and MEM_WRITE.
// TESTING
//  1. Reset, ready=1, opcode=000000 -> state 0,1,6,7,0.
//     pc_write=ir_write=1 in FETCH; reg_write=1 and reg_dst=1 only in R_WB; 4 cycles.
//  2. lw (100011), ready low 2 cycles in MEM_READ -> states 0,1,2,3,3,3,4,0.
//     mem_read and iord high through MEM_READ; reg_write and mem_to_reg high in MEM_WB.
//  3. beq with zero=1 -> pc_write=1, pc_src=1 in BRANCH.
//     bne with zero=1 -> pc_write=0 in BRANCH. Both return to FETCH after 3 cycles.
//  4. opcode=111111 in DECODE -> state 15, error_o=1.
//     Stays there for 20 cycles regardless of inputs; reset returns to state 0.
//  5. WAIT_LIMIT=3, ready held 0 in FETCH -> ERROR after 4 cycles in FETCH.
//     Repeat with ready=1 on the limit cycle -> DECODE, no error.
//  6. Assert reset during MEM_WRITE (sw) -> mem_write falls the same cycle.
//     After release: state 0, mem_read=1, no register write occurred.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared memory, ALU and register file, with a memory-ready watchdog.
module multicycle_control #(
   parameter int WAIT_LIMIT = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode_i,
   input  logic       zero_i,
   input  logic       mem_ready_i,
   output logic       pc_write_o,
   output logic       iord_o,
   output logic       mem_read_o,
   output logic       mem_write_o,
   output logic       ir_write_o,
   output logic       reg_dst_o,
   output logic       mem_to_reg_o,
   output logic       reg_write_o,
   output logic       alu_src_a_o,
   output logic [1:0] alu_src_b_o,
   output logic [2:0] alu_op_o,
   output logic       pc_src_o,
   output logic [3:0] state_o,
   output logic       error_o
);

   typedef enum logic [3:0] {
      FETCH     = 4'd0,
      DECODE    = 4'd1,
      MEM_ADDR  = 4'd2,
      MEM_READ  = 4'd3,
      MEM_WB    = 4'd4,
      MEM_WRITE = 4'd5,
      R_EXEC    = 4'd6,
      R_WB      = 4'd7,
      I_EXEC    = 4'd8,
      I_WB      = 4'd9,
      BRANCH    = 4'd10,
      ERROR     = 4'd15
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [7:0] LIMIT   = 8'(WAIT_LIMIT);

   state_t     state, state_nxt;
   logic [7:0] wait_cnt;
   logic [5:0] op_q;
   logic       waiting;

   assign waiting = (state == FETCH) || (state == MEM_READ) || (state == MEM_WRITE);
   assign state_o = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= FETCH;
         wait_cnt <= 8'd0;
         op_q     <= 6'd0;
      end else begin
         state <= state_nxt;
         if (state_nxt != state)
            wait_cnt <= 8'd0;
         else if (waiting && !mem_ready_i)
            wait_cnt <= wait_cnt + 8'd1;
         if (state == DECODE)
            op_q <= opcode_i;
      end
   end

   always_comb begin
      state_nxt    = state;
      pc_write_o   = 1'b0;
      iord_o       = 1'b0;
      mem_read_o   = 1'b0;
      mem_write_o  = 1'b0;
      ir_write_o   = 1'b0;
      reg_dst_o    = 1'b0;
      mem_to_reg_o = 1'b0;
      reg_write_o  = 1'b0;
      alu_src_a_o  = 1'b0;
      alu_src_b_o  = 2'b00;
      alu_op_o     = 3'b000;
      pc_src_o     = 1'b0;
      error_o      = 1'b0;

      // Stall states share the watchdog: ready wins over an expired count.
      if (waiting && !mem_ready_i && wait_cnt >= LIMIT)
         state_nxt = ERROR;

      case (state)
         FETCH: begin
            mem_read_o  = 1'b1;
            alu_src_b_o = 2'b01;
            if (mem_ready_i) begin
               ir_write_o = 1'b1;
               pc_write_o = 1'b1;
               state_nxt  = DECODE;
            end
         end
         DECODE: begin
            alu_src_b_o = 2'b11;
            case (opcode_i)
               OP_R:            state_nxt = R_EXEC;
               OP_ADDI, OP_ORI: state_nxt = I_EXEC;
               OP_LW, OP_SW:    state_nxt = MEM_ADDR;
               OP_BEQ, OP_BNE:  state_nxt = BRANCH;
               default:         state_nxt = ERROR;
            endcase
         end
         MEM_ADDR: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = 2'b10;
            state_nxt   = (op_q == OP_LW) ? MEM_READ : MEM_WRITE;
         end
         MEM_READ: begin
            iord_o     = 1'b1;
            mem_read_o = 1'b1;
            if (mem_ready_i) state_nxt = MEM_WB;
         end
         MEM_WB: begin
            mem_to_reg_o = 1'b1;
            reg_write_o  = 1'b1;
            state_nxt    = FETCH;
         end
         MEM_WRITE: begin
            iord_o      = 1'b1;
            mem_write_o = 1'b1;
            if (mem_ready_i) state_nxt = FETCH;
         end
         R_EXEC: begin
            alu_src_a_o = 1'b1;
            alu_op_o    = 3'b010;
            state_nxt   = R_WB;
         end
         R_WB: begin
            reg_dst_o   = 1'b1;
            reg_write_o = 1'b1;
            state_nxt   = FETCH;
         end
         I_EXEC: begin
            alu_src_a_o = 1'b1;
            alu_src_b_o = 2'b10;
            alu_op_o    = (op_q == OP_ORI) ? 3'b011 : 3'b000;
            state_nxt   = I_WB;
         end
         I_WB: begin
            reg_write_o = 1'b1;
            state_nxt   = FETCH;
         end
         BRANCH: begin
            alu_src_a_o = 1'b1;
            alu_op_o    = 3'b001;
            pc_src_o    = 1'b1;
            pc_write_o  = ((op_q == OP_BEQ) & zero_i) | ((op_q == OP_BNE) & ~zero_i);
            state_nxt   = FETCH;
         end
         ERROR: begin
            error_o   = 1'b1;
            state_nxt = ERROR;
         end
         default: state_nxt = ERROR;
      endcase

      // Strobes drop the instant reset rises, not at the next edge.
      if (reset) begin
         pc_write_o   = 1'b0;
         iord_o       = 1'b0;
         mem_read_o   = 1'b0;
         mem_write_o  = 1'b0;
         ir_write_o   = 1'b0;
         reg_dst_o    = 1'b0;
         mem_to_reg_o = 1'b0;
         reg_write_o  = 1'b0;
         alu_src_a_o  = 1'b0;
         alu_src_b_o  = 2'b00;
         alu_op_o     = 3'b000;
         pc_src_o     = 1'b0;
         error_o      = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected state traces built from
// instruction class and wait counts, checked every cycle on two watchdog limits.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic       zero;
   logic       ready;

   logic       pcw0, iord0, mr0, mw0, irw0, rd0, m2r0, rw0, a0, ps0, err0;
   logic [1:0] b0;
   logic [2:0] op0;
   logic [3:0] st0;
   logic       pcw3, iord3, mr3, mw3, irw3, rd3, m2r3, rw3, a3, ps3, err3;
   logic [1:0] b3;
   logic [2:0] op3;
   logic [3:0] st3;

   int checks = 0;
   int errors = 0;

   localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h08, OP_ORI = 6'h0d, OP_LW = 6'h23,
                          OP_SW = 6'h2b, OP_BEQ = 6'h04, OP_BNE = 6'h05;

   always #5 clk = ~clk;

   multicycle_control dut0 (
      .clk(clk), .reset(reset), .opcode_i(opcode), .zero_i(zero), .mem_ready_i(ready),
      .pc_write_o(pcw0), .iord_o(iord0), .mem_read_o(mr0), .mem_write_o(mw0),
      .ir_write_o(irw0), .reg_dst_o(rd0), .mem_to_reg_o(m2r0), .reg_write_o(rw0),
      .alu_src_a_o(a0), .alu_src_b_o(b0), .alu_op_o(op0), .pc_src_o(ps0),
      .state_o(st0), .error_o(err0));

   multicycle_control #(.WAIT_LIMIT(3)) dut3 (
      .clk(clk), .reset(reset), .opcode_i(opcode), .zero_i(zero), .mem_ready_i(ready),
      .pc_write_o(pcw3), .iord_o(iord3), .mem_read_o(mr3), .mem_write_o(mw3),
      .ir_write_o(irw3), .reg_dst_o(rd3), .mem_to_reg_o(m2r3), .reg_write_o(rw3),
      .alu_src_a_o(a3), .alu_src_b_o(b3), .alu_op_o(op3), .pc_src_o(ps3),
      .state_o(st3), .error_o(err3));

   // {pc_write,iord,mem_read,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,src_a,src_b,alu_op,pc_src,state,error}
   wire [19:0] o0 = {pcw0, iord0, mr0, mw0, irw0, rd0, m2r0, rw0, a0, b0, op0, ps0, st0, err0};
   wire [19:0] o3 = {pcw3, iord3, mr3, mw3, irw3, rd3, m2r3, rw3, a3, b3, op3, ps3, st3, err3};

   // Expected outputs for one cycle, straight from the per-state output table.
   function automatic logic [19:0] exp_out(int st, logic [5:0] op, logic rdy, logic z);
      logic br;
      br = ((op == OP_BEQ) && z) || ((op == OP_BNE) && !z);
      case (st)
         0:  return {rdy, 1'b0, 1'b1, 1'b0, rdy, 3'b000, 1'b0, 2'b01, 3'b000, 1'b0, 4'd0, 1'b0};
         1:  return {8'b0, 1'b0, 2'b11, 3'b000, 1'b0, 4'd1, 1'b0};
         2:  return {8'b0, 1'b1, 2'b10, 3'b000, 1'b0, 4'd2, 1'b0};
         3:  return {8'b0110_0000, 1'b0, 2'b00, 3'b000, 1'b0, 4'd3, 1'b0};
         4:  return {8'b0000_0011, 1'b0, 2'b00, 3'b000, 1'b0, 4'd4, 1'b0};
         5:  return {8'b0101_0000, 1'b0, 2'b00, 3'b000, 1'b0, 4'd5, 1'b0};
         6:  return {8'b0, 1'b1, 2'b00, 3'b010, 1'b0, 4'd6, 1'b0};
         7:  return {8'b0000_0101, 1'b0, 2'b00, 3'b000, 1'b0, 4'd7, 1'b0};
         8:  return {8'b0, 1'b1, 2'b10, (op == OP_ORI) ? 3'b011 : 3'b000, 1'b0, 4'd8, 1'b0};
         9:  return {8'b0000_0001, 1'b0, 2'b00, 3'b000, 1'b0, 4'd9, 1'b0};
         10: return {br, 7'b0, 1'b1, 2'b00, 3'b001, 1'b1, 4'd10, 1'b0};
         default: return {8'b0, 1'b0, 2'b00, 3'b000, 1'b0, 4'd15, 1'b1};
      endcase
   endfunction

   int st_q[$];
   bit rdy_q[$];

   task automatic push(int st, bit rdy);
      st_q.push_back(st);
      rdy_q.push_back(rdy);
   endtask

   // Called at posedge+1; leaves at posedge+1 of the cycle after the trace.
   task automatic run_instr(logic [5:0] op, int fw, int mw, logic z, bit chk3);
      logic [19:0] e;
      st_q.delete();
      rdy_q.delete();
      repeat (fw) push(0, 0);
      push(0, 1);
      push(1, 1'($urandom));
      case (op)
         OP_R: begin push(6, 1'($urandom)); push(7, 1'($urandom)); end
         OP_ADDI, OP_ORI: begin push(8, 1'($urandom)); push(9, 1'($urandom)); end
         OP_LW: begin
            push(2, 1'($urandom)); repeat (mw) push(3, 0); push(3, 1); push(4, 1'($urandom));
         end
         OP_SW: begin
            push(2, 1'($urandom)); repeat (mw) push(5, 0); push(5, 1);
         end
         OP_BEQ, OP_BNE: push(10, 1'($urandom));
         default: push(15, 1'($urandom));
      endcase
      for (int i = 0; i < st_q.size(); i++) begin
         opcode = (st_q[i] == 1) ? op : 6'($urandom);
         ready  = rdy_q[i];
         zero   = (st_q[i] == 10) ? z : 1'($urandom);
         e = exp_out(st_q[i], op, rdy_q[i], zero);
         @(negedge clk);
         checks++;
         if (o0 !== e) begin
            errors++;
            $display("FAIL instr op=%h cyc=%0d lim15: got %h want %h", op, i, o0, e);
         end
         if (chk3) begin
            checks++;
            if (o3 !== e) begin
               errors++;
               $display("FAIL instr op=%h cyc=%0d lim3: got %h want %h", op, i, o3, e);
            end
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      ready = 1'($urandom);
      opcode = 6'($urandom);
      @(negedge clk);
      checks++;
      if (o0 !== 20'h0 || o3 !== 20'h0) begin
         errors++;
         $display("FAIL reset_outputs: got %h/%h want 00000", o0, o3);
      end
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; opcode = 6'd0; zero = 1'b0; ready = 1'b1;
      #12;
      checks++;
      if (o0 !== 20'h0) begin
         errors++;
         $display("FAIL test_reset: got %h want 00000", o0);
      end
      do_reset();
   endtask

   task automatic test_rtype();
      run_instr(OP_R, 0, 0, 0, 1);
      run_instr(OP_ADDI, 1, 0, 0, 1);
      run_instr(OP_ORI, 0, 0, 1, 1);
      run_instr(OP_SW, 0, 0, 0, 1);
   endtask

   task automatic test_lw();
      run_instr(OP_LW, 0, 2, 0, 1);
      run_instr(OP_LW, 0, 0, 1, 1);
   endtask

   task automatic test_branch();
      run_instr(OP_BEQ, 0, 0, 1, 1);
      run_instr(OP_BNE, 0, 0, 1, 1);
      run_instr(OP_BEQ, 0, 0, 0, 1);
      run_instr(OP_BNE, 0, 0, 0, 1);
   endtask

   task automatic test_illegal();
      run_instr(6'h3f, 0, 0, 0, 1);
      for (int i = 0; i < 20; i++) begin
         ready = 1'($urandom); zero = 1'($urandom); opcode = 6'($urandom);
         @(negedge clk);
         checks++;
         if (o0 !== exp_out(15, 0, 0, 0)) begin
            errors++;
            $display("FAIL illegal_sticky cyc=%0d: got %h", i, o0);
         end
         @(posedge clk); #1;
      end
      do_reset();
      ready = 1'b0;
      @(negedge clk);
      checks++;
      if (o0 !== exp_out(0, 0, 0, 0)) begin
         errors++;
         $display("FAIL illegal_recover: got %h want %h", o0, exp_out(0, 0, 0, 0));
      end
      @(posedge clk); #1;
      do_reset();
   endtask

   // Stall FETCH for n cycles on the given instance, then expect ERROR.
   task automatic stall_to_error(int n, bit on3);
      for (int i = 0; i <= n; i++) begin
         ready = 1'b0; opcode = 6'($urandom);
         @(negedge clk);
         checks++;
         if ((on3 ? o3 : o0) !== exp_out((i == n) ? 15 : 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL timeout lim=%0d cyc=%0d: got %h", on3 ? 3 : 15, i, on3 ? o3 : o0);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_timeout();
      stall_to_error(4, 1);
      do_reset();
      run_instr(OP_ADDI, 3, 0, 0, 1);
      run_instr(OP_LW, 3, 3, 0, 1);
      do_reset();
      run_instr(OP_ADDI, 15, 0, 0, 0);
      stall_to_error(16, 0);
      do_reset();
   endtask

   task automatic test_reset_mid_write();
      run_instr(OP_R, 0, 0, 0, 1);
      ready = 1'b1; @(posedge clk); #1;
      opcode = OP_SW; @(posedge clk); #1;
      opcode = 6'd0; ready = 1'b0; @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (mw0 !== 1'b1) begin
         errors++;
         $display("FAIL mid_write_pre: mem_write=%b want 1", mw0);
      end
      #1 reset = 1'b1;
      #1;
      checks++;
      if (o0 !== 20'h0) begin
         errors++;
         $display("FAIL mid_write_drop: got %h want 00000", o0);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (o0 !== exp_out(0, 0, 0, 0)) begin
         errors++;
         $display("FAIL mid_write_restart: got %h want %h", o0, exp_out(0, 0, 0, 0));
      end
      @(posedge clk); #1;
      run_instr(OP_BEQ, 0, 0, 1, 1);
   endtask

   task automatic test_random();
      logic [5:0] ops [8] = '{OP_R, OP_ADDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_BNE, 6'h00};
      logic [5:0] op;
      for (int n = 0; n < 150; n++) begin
         op = ops[$urandom_range(0, 6)];
         if ($urandom_range(0, 15) == 0) op = 6'($urandom);
         run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1);
         if (!(op inside {OP_R, OP_ADDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_BNE}))
            do_reset();
      end
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_lw();
      test_branch();
      test_illegal();
      test_timeout();
      test_reset_mid_write();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
